// File: rtl/cpu_irq_timer_if.sv
// Bus bundle between the cpu4510 data path (master) and the irq/nmi timer responder (slave).
// Carries the next-cycle decoded access plus the registered read data and interrupt levels.
interface cpu_irq_timer_if;
   logic       cs;
   logic [2:0] addr;
   logic       write;
   logic       ready;
   logic [7:0] data_i;
   logic [7:0] data_o;
   logic       irq;
   logic       nmi;

   modport master (output cs, addr, write, ready, data_i, input data_o, irq, nmi);
   modport slave  (input cs, addr, write, ready, data_i, output data_o, irq, nmi);
endinterface

// File: rtl/cpu_irq_timer.sv
// Memory-mapped interrupt source: reloadable 16-bit down-counter, software interrupt,
// flag/mask registers with read-to-clear, driving the CPU irq and nmi levels.
module cpu_irq_timer #(
   parameter int PRESCALE = 1
) (
   input  logic           clk,
   input  logic           reset,
   cpu_irq_timer_if.slave bus
);
   localparam logic [7:0] PMAX = 8'(PRESCALE - 1);

   logic [15:0] latch, counter, load_val;
   logic [7:0]  presc, cnt_hi_snap, rdata, rd_mux;
   logic        start, oneshot, nmi_route;
   logic [1:0]  mask;            // {sw, timer}
   logic        flag_t, flag_sw;
   logic        wr_acc, rd_acc, icr_rd, swi_set, load, tick, underflow;
   logic        irq_w, nmi_w;

   assign wr_acc  = bus.cs & bus.write & bus.ready;
   assign rd_acc  = bus.cs & ~bus.write & bus.ready;
   assign icr_rd  = rd_acc & (bus.addr == 3'd3);
   assign swi_set = wr_acc & (bus.addr == 3'd4) & bus.data_i[0];

   // A THI write while stopped loads with the incoming high byte, not the stale one.
   always_comb begin
      load     = 1'b0;
      load_val = latch;
      if (wr_acc && bus.addr == 3'd1 && !start) begin
         load     = 1'b1;
         load_val = {bus.data_i, latch[7:0]};
      end else if (wr_acc && bus.addr == 3'd2 && bus.data_i[2]) begin
         load = 1'b1;
      end
   end

   assign tick      = (presc == PMAX) & start;
   assign underflow = tick & ~load & (counter == 16'd0);

   assign irq_w        = (flag_t & mask[0] & ~nmi_route) | (flag_sw & mask[1]);
   assign nmi_w        = flag_t & mask[0] & nmi_route;
   assign bus.irq      = irq_w;
   assign bus.nmi      = nmi_w;
   assign bus.data_o   = rdata;

   always_comb begin
      rd_mux = 8'h00;
      case (bus.addr)
         3'd0: rd_mux = latch[7:0];
         3'd1: rd_mux = latch[15:8];
         3'd2: rd_mux = {4'b0, nmi_route, 1'b0, oneshot, start};
         3'd3: rd_mux = {irq_w | nmi_w, 5'b0, flag_sw, flag_t};
         3'd5: rd_mux = counter[7:0];
         3'd6: rd_mux = cnt_hi_snap;
         default: rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         latch       <= 16'hFFFF;
         counter     <= 16'hFFFF;
         presc       <= 8'h00;
         start       <= 1'b0;
         oneshot     <= 1'b0;
         nmi_route   <= 1'b0;
         mask        <= 2'b00;
         flag_t      <= 1'b0;
         flag_sw     <= 1'b0;
         cnt_hi_snap <= 8'h00;
         rdata       <= 8'h00;
      end else begin
         presc <= (load || presc == PMAX) ? 8'h00 : presc + 8'd1;

         if (load)
            counter <= load_val;
         else if (tick)
            counter <= (counter == 16'd0) ? latch : counter - 16'd1;

         // A same-cycle CTRL write lands after the one-shot stop, so software has the last word.
         if (underflow && oneshot)
            start <= 1'b0;

         if (wr_acc) begin
            case (bus.addr)
               3'd0: latch[7:0]  <= bus.data_i;
               3'd1: latch[15:8] <= bus.data_i;
               3'd2: begin
                  start     <= bus.data_i[0];
                  oneshot   <= bus.data_i[1];
                  nmi_route <= bus.data_i[3];
               end
               3'd3: mask <= bus.data_i[7] ? (mask | bus.data_i[1:0])
                                           : (mask & ~bus.data_i[1:0]);
               default: ;
            endcase
         end

         // Set beats read-to-clear so an event landing on the ICR read is never lost.
         flag_t  <= underflow | (flag_t & ~icr_rd);
         flag_sw <= swi_set | (flag_sw & ~icr_rd);

         if (rd_acc) begin
            rdata <= rd_mux;
            if (bus.addr == 3'd5)
               cnt_hi_snap <= counter[15:8];
         end
      end
   end
endmodule

// File: tb/tb_cpu_irq_timer.sv
// Self-checking bench for cpu_irq_timer: directed scenarios plus a randomized bus run
// against a behavioural model; a second instance with PRESCALE=4 shares the same bus traffic.
module tb_cpu_irq_timer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errs = 0;
  int cyc = 0;

  cpu_irq_timer_if b1();
  cpu_irq_timer_if b4();

  assign b4.cs     = b1.cs;
  assign b4.addr   = b1.addr;
  assign b4.write  = b1.write;
  assign b4.ready  = b1.ready;
  assign b4.data_i = b1.data_i;

  cpu_irq_timer #(.PRESCALE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  cpu_irq_timer #(.PRESCALE(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // one bus access at the next posedge; call at a negedge, returns at the following negedge
  task automatic acc(input logic w, input logic [2:0] a, input logic [7:0] d);
    b1.cs = 1'b1; b1.write = w; b1.addr = a; b1.data_i = d; b1.ready = 1'b1;
    @(negedge clk);
    b1.cs = 1'b0; b1.write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_nmi(input int sel, output int t, output bit ok);
    ok = 1'b0;
    t = cyc;
    for (int i = 0; i < 64; i++) begin
      if ((sel == 1) ? b1.nmi : b4.nmi) begin
        ok = 1'b1;
        t = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (b1.data_o !== 8'h00) begin errs++; $display("FAIL rst_data_o got %h exp 00", b1.data_o); end
    checks++; if (b1.irq !== 1'b0) begin errs++; $display("FAIL rst_irq got %b exp 0", b1.irq); end
    checks++; if (b1.nmi !== 1'b0) begin errs++; $display("FAIL rst_nmi got %b exp 0", b1.nmi); end
    reset = 1'b1;
    @(negedge clk);
    acc(1, 3'd0, 8'h02); acc(1, 3'd1, 8'h00); acc(1, 3'd3, 8'h81); acc(1, 3'd2, 8'h09);
    repeat (5) @(negedge clk);
    checks++; if (b1.nmi !== 1'b1) begin errs++; $display("FAIL run_nmi got %b exp 1", b1.nmi); end
    acc(0, 3'd2, 8'h00);
    checks++; if (b1.data_o !== 8'h09) begin errs++; $display("FAIL run_ctrl got %h exp 09", b1.data_o); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({b1.irq, b1.nmi, b1.data_o} !== 10'h000) begin errs++;
      $display("FAIL async_rst got irq=%b nmi=%b d=%h exp 0 0 00", b1.irq, b1.nmi, b1.data_o); end
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (b1.nmi !== 1'b0) begin errs++; $display("FAIL post_rst_nmi got %b exp 0", b1.nmi); end
    acc(0, 3'd2, 8'h00);
    checks++; if (b1.data_o !== 8'h00) begin errs++; $display("FAIL post_rst_ctrl got %h exp 00", b1.data_o); end
    acc(0, 3'd5, 8'h00);
    checks++; if (b1.data_o !== 8'hFF) begin errs++; $display("FAIL post_rst_cntlo got %h exp FF", b1.data_o); end
  endtask

  task automatic test_oneshot();
    do_reset();
    acc(1, 3'd0, 8'h03); acc(1, 3'd1, 8'h00); acc(1, 3'd3, 8'h81); acc(1, 3'd2, 8'h03);
    for (int i = 0; i <= 4; i++) begin
      checks++; if (b1.irq !== (i == 4)) begin errs++;
        $display("FAIL oneshot_irq_c%0d got %b exp %b", i, b1.irq, (i == 4)); end
      if (i < 4) @(negedge clk);
    end
    acc(0, 3'd2, 8'h00);
    checks++; if (b1.data_o !== 8'h02) begin errs++; $display("FAIL oneshot_ctrl got %h exp 02", b1.data_o); end
    acc(0, 3'd3, 8'h00);
    checks++; if (b1.data_o !== 8'h81) begin errs++; $display("FAIL oneshot_icr1 got %h exp 81", b1.data_o); end
    checks++; if (b1.irq !== 1'b0) begin errs++; $display("FAIL oneshot_irq_clr got %b exp 0", b1.irq); end
    acc(0, 3'd3, 8'h00);
    checks++; if (b1.data_o !== 8'h00) begin errs++; $display("FAIL oneshot_icr2 got %h exp 00", b1.data_o); end
  endtask

  task automatic test_nmi_route();
    int t1, t2;
    bit ok1, ok2;
    do_reset();
    acc(1, 3'd0, 8'h02); acc(1, 3'd1, 8'h00); acc(1, 3'd3, 8'h81); acc(1, 3'd2, 8'h09);
    for (int sel = 1; sel <= 4; sel += 3) begin
      acc(0, 3'd3, 8'h00);
      wait_nmi(sel, t1, ok1);
      acc(0, 3'd3, 8'h00);
      checks++; if (b1.data_o !== 8'h81 && sel == 1) begin errs++;
        $display("FAIL nmi_icr got %h exp 81", b1.data_o); end
      wait_nmi(sel, t2, ok2);
      checks++; if (!(ok1 && ok2) || (t2 - t1) != sel * 3) begin errs++;
        $display("FAIL nmi_period_p%0d got %0d (seen %b%b) exp %0d", sel, t2 - t1, ok1, ok2, sel * 3); end
      checks++; if (b1.irq !== 1'b0 || b4.irq !== 1'b0) begin errs++;
        $display("FAIL nmi_irq_quiet got %b%b exp 00", b1.irq, b4.irq); end
    end
  endtask

  task automatic test_swi();
    do_reset();
    acc(1, 3'd3, 8'h82);
    acc(1, 3'd4, 8'h01);
    checks++; if (b1.irq !== 1'b1) begin errs++; $display("FAIL swi_irq got %b exp 1", b1.irq); end
    acc(1, 3'd3, 8'h02);
    checks++; if (b1.irq !== 1'b0) begin errs++; $display("FAIL swi_mask_clr got %b exp 0", b1.irq); end
    acc(0, 3'd3, 8'h00);
    checks++; if (b1.data_o !== 8'h02) begin errs++; $display("FAIL swi_icr got %h exp 02", b1.data_o); end
  endtask

  task automatic test_collision();
    do_reset();
    acc(1, 3'd0, 8'h03); acc(1, 3'd1, 8'h00); acc(1, 3'd3, 8'h81); acc(1, 3'd2, 8'h01);
    repeat (3) @(negedge clk);
    acc(0, 3'd3, 8'h00);
    checks++; if (b1.data_o !== 8'h00) begin errs++; $display("FAIL coll_icr got %h exp 00", b1.data_o); end
    checks++; if (b1.irq !== 1'b1) begin errs++; $display("FAIL coll_irq got %b exp 1", b1.irq); end
    acc(0, 3'd3, 8'h00);
    checks++; if (b1.data_o !== 8'h81) begin errs++; $display("FAIL coll_flag got %h exp 81", b1.data_o); end
  endtask

  task automatic test_snapshot();
    logic [7:0] lo, hi;
    logic [15:0] exp_cnt;
    do_reset();
    acc(1, 3'd0, 8'h05); acc(1, 3'd1, 8'h12); acc(1, 3'd2, 8'h01);
    repeat (5) @(negedge clk);
    acc(0, 3'd5, 8'h00); lo = b1.data_o;
    acc(0, 3'd6, 8'h00); hi = b1.data_o;
    exp_cnt = 16'h1205 - 16'd5;
    checks++; if ({hi, lo} !== exp_cnt) begin errs++; $display("FAIL snapshot got %h exp %h", {hi, lo}, exp_cnt); end
  endtask

  task automatic test_ready_gating();
    do_reset();
    acc(1, 3'd3, 8'h82);
    b1.cs = 1'b1; b1.write = 1'b1; b1.addr = 3'd4; b1.data_i = 8'h01; b1.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (b1.irq !== 1'b0) begin errs++; $display("FAIL rdy_hold_c%0d got %b exp 0", i, b1.irq); end
    end
    b1.ready = 1'b1;
    @(negedge clk);
    b1.cs = 1'b0; b1.write = 1'b0;
    checks++; if (b1.irq !== 1'b1) begin errs++; $display("FAIL rdy_release got %b exp 1", b1.irq); end
    b1.cs = 1'b1; b1.write = 1'b1; b1.addr = 3'd2; b1.data_i = 8'h01; b1.ready = 1'b0;
    repeat (4) @(negedge clk);
    b1.cs = 1'b0; b1.write = 1'b0; b1.ready = 1'b1;
    acc(0, 3'd2, 8'h00);
    checks++; if (b1.data_o !== 8'h00) begin errs++; $display("FAIL rdy_ctrl got %h exp 00", b1.data_o); end
  endtask

  // reference model of the PRESCALE=1 instance, one call per clock edge
  logic [15:0] m_latch, m_cnt;
  logic        m_start, m_one, m_nr, m_ft, m_fs;
  logic [1:0]  m_mask;
  logic [7:0]  m_snap, m_dout;

  function automatic logic m_irq();
    return (m_ft && m_mask[0] && !m_nr) || (m_fs && m_mask[1]);
  endfunction
  function automatic logic m_nmi();
    return m_ft && m_mask[0] && m_nr;
  endfunction

  task automatic model_step(input logic cs, input logic w, input logic rdy,
                            input logic [2:0] a, input logic [7:0] d);
    bit rd, wr, loaded, wrapped;
    logic [15:0] old_latch, old_cnt;
    rd = cs && !w && rdy;
    wr = cs && w && rdy;
    old_latch = m_latch;
    old_cnt = m_cnt;
    if (rd) begin
      case (a)
        3'd0: m_dout = m_latch[7:0];
        3'd1: m_dout = m_latch[15:8];
        3'd2: m_dout = {4'h0, m_nr, 1'b0, m_one, m_start};
        3'd3: m_dout = {m_irq() || m_nmi(), 5'b0, m_fs, m_ft};
        3'd5: begin m_dout = m_cnt[7:0]; m_snap = m_cnt[15:8]; end
        3'd6: m_dout = m_snap;
        default: m_dout = 8'h00;
      endcase
    end
    loaded = 1'b0;
    wrapped = 1'b0;
    if (wr && a == 3'd1 && !m_start) begin m_cnt = {d, old_latch[7:0]}; loaded = 1'b1; end
    if (wr && a == 3'd2 && d[2]) begin m_cnt = old_latch; loaded = 1'b1; end
    if (!loaded && m_start) begin
      if (old_cnt == 16'd0) begin
        wrapped = 1'b1;
        m_cnt = old_latch;
        if (m_one) m_start = 1'b0;
      end else begin
        m_cnt = old_cnt - 16'd1;
      end
    end
    if (rd && a == 3'd3) begin m_ft = 1'b0; m_fs = 1'b0; end
    if (wrapped) m_ft = 1'b1;
    if (wr && a == 3'd4 && d[0]) m_fs = 1'b1;
    if (wr) begin
      case (a)
        3'd0: m_latch[7:0] = d;
        3'd1: m_latch[15:8] = d;
        3'd2: begin m_start = d[0]; m_one = d[1]; m_nr = d[3]; end
        3'd3: for (int k = 0; k < 2; k++) if (d[k]) m_mask[k] = d[7];
        default: ;
      endcase
    end
  endtask

  task automatic test_random();
    logic cs, w, rdy;
    logic [2:0] a;
    logic [7:0] d;
    do_reset();
    m_latch = 16'hFFFF; m_cnt = 16'hFFFF; m_start = 0; m_one = 0; m_nr = 0;
    m_ft = 0; m_fs = 0; m_mask = 0; m_snap = 0; m_dout = 0;
    for (int n = 0; n < 400; n++) begin
      cs  = ($urandom_range(0, 3) != 0);
      w   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 4) != 0);
      a   = 3'($urandom_range(0, 7));
      case (a)
        3'd0: d = 8'($urandom_range(0, 6));
        3'd1: d = 8'h00;
        3'd2: d = 8'($urandom_range(0, 15));
        3'd3: d = {1'($urandom_range(0, 1)), 5'b0, 2'($urandom_range(0, 3))};
        default: d = 8'($urandom_range(0, 255));
      endcase
      b1.cs = cs; b1.write = w; b1.ready = rdy; b1.addr = a; b1.data_i = d;
      model_step(cs, w, rdy, a, d);
      @(negedge clk);
      checks++; if ({b1.data_o, b1.irq, b1.nmi} !== {m_dout, m_irq(), m_nmi()}) begin errs++;
        $display("FAIL rand_c%0d got d=%h irq=%b nmi=%b exp d=%h irq=%b nmi=%b",
                 n, b1.data_o, b1.irq, b1.nmi, m_dout, m_irq(), m_nmi()); end
    end
    b1.cs = 1'b0; b1.write = 1'b0; b1.ready = 1'b1;
  endtask

  initial begin
    b1.cs = 1'b0; b1.write = 1'b0; b1.addr = 3'd0; b1.data_i = 8'h00; b1.ready = 1'b1;
    test_reset();
    test_oneshot();
    test_nmi_route();
    test_swi();
    test_collision();
    test_snapshot();
    test_ready_gating();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule

// File: doc/cpu_irq_timer.md
Name: cpu_irq_timer

Overview:
- Memory-mapped interrupt source that sits on the cpu4510 data bus as a responder. It is decoded from cpu_address_next and write_next, and drives the CPU irq and nmi inputs.
- It replaces the ad-hoc io_port irq/nmi bits with the following functions:
  - a reloadable 16-bit down-counter timer;
  - a software interrupt;
  - interrupt flag and mask registers with read-to-clear.
- Read data follows the same bus timing as every other responder: it is registered on the access edge, and the top-level data mux selects it on the following cycle.

Parameters:
- PRESCALE, 1, number of clk cycles per timer tick (1..256). With 1 the timer ticks every cycle.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  chip select, decoded from cpu_address_next by the top level.
- addr  in  3  register index, cpu_address_next[2:0].
- write  in  1  cpu write_next.
- ready  in  1  bus ready. An access only takes effect when cs & ready.
- data_i  in  8  cpu data_o_next (write data).
- data_o  out  8  registered read data.
- irq  out  1  active-high level interrupt to the CPU.
- nmi  out  1  active-high level NMI to the CPU.

Behaviour:
- Access definitions:
  - write access = cs & write & ready at a posedge.
  - read access = cs & !write & ready at a posedge.
  - No other combination alters any state.
- Register map:
  - 0 TLO: timer latch low byte. Read/write.
  - 1 THI: timer latch high byte. Read/write. A write while CTRL.start=0 also loads the counter from {THI,TLO}, using the new THI value.
  - 2 CTRL: read/write.
    - bit0 start.
    - bit1 oneshot.
    - bit2 force-load strobe. Always reads 0. Loads the counter from the latch.
    - bit3 nmi_route.
    - bits 7:4 read 0.
  - 3 ICR:
    - Read returns {pending, 5'b0, flag_sw, flag_t}, where pending = irq|nmi. The read then clears both flags.
    - Write with data_i[7]=1 sets the mask bits selected by data_i[1:0]. Write with data_i[7]=0 clears them.
  - 4 SWI: a write with data_i[0]=1 sets flag_sw. Reads 0.
  - 5 CNTLO: returns counter[7:0] and snapshots counter[15:8] into cnt_hi_snap.
  - 6 CNTHI: returns cnt_hi_snap.
  - 7: reads 0; writes are ignored.
- Read data:
  - data_o is loaded on a read access edge and holds its value until the next read access.
  - Latency is 1 cycle from the access edge.
  - data_o reflects register state from before that edge's updates.
- Prescaler:
  - The counter counts 0..PRESCALE-1 every clk, regardless of ready.
  - tick = (prescaler == PRESCALE-1) & start.
  - The prescaler is reset to 0 on any counter load.
- Timer:
  - On a tick, if counter==0: reload the counter from the latch, set flag_t, and if oneshot clear start. Otherwise decrement the counter.
  - A latch of 0 with start=1 underflows on every tick.
- Outputs:
  - irq = (flag_t & mask_t & !nmi_route) | (flag_sw & mask_sw).
  - nmi = flag_t & mask_t & nmi_route.
  - Both are registered-state-derived only, with no combinational path from bus inputs.
- Priority and simultaneity:
  - A load (force-load or THI write) in the same cycle as a tick: the load wins and no underflow occurs.
  - flag_t set in the same cycle as an ICR read: the set wins (flag stays 1), and data_o shows the pre-edge value.
  - The same set-wins rule applies to flag_sw when an SWI write and an ICR read collide (impossible on one bus, but required).
  - A CTRL write of start=0 in the same cycle as an underflow: the underflow completes, then start=0.
  - A CTRL write of oneshot with start=1 takes effect from the next tick.
- Reset (asynchronous, reset=0):
  - latch = 16'hFFFF, counter = 16'hFFFF.
  - CTRL = 0, mask = 0, flags = 0, prescaler = 0.
  - cnt_hi_snap = 0, data_o = 0, irq = 0, nmi = 0.
  - Reset asserted mid-count aborts the count immediately. After release the timer is stopped.
- Writes while ready=0 are dropped. The CPU holds the access until ready, so each access is counted once.

Test Plan:
- Reset: pulse reset low mid-run with timer active → irq=0, nmi=0, data_o=00, and reading CTRL gives 00 after release.
- One-shot: PRESCALE=1; write TLO=03, THI=00, ICR=81, CTRL=03 →
  - irq rises 4 cycles after the CTRL write edge (count 3,2,1,0, then underflow on the 4th tick);
  - CTRL then reads 02;
  - ICR read returns 81 and irq drops the next cycle;
  - a second ICR read returns 00.
- Continuous with NMI route: latch 0002, CTRL=09, ICR=81 →
  - nmi asserts every 3 ticks (after each ICR clear);
  - irq stays 0.
  - With PRESCALE=4 the period is 12 cycles.
- Software interrupt: write ICR=82, then SWI=01 → irq=1 the cycle after the write. Write ICR=02 (mask clear) → irq=0, and a subsequent ICR read still returns 02.
- Collision: arrange an underflow on the same edge as an ICR read → data_o bit0=0, flag_t remains set, irq stays 1.
- Counter snapshot and ready gating:
  - Read CNTLO while counting, then CNTHI → the pair forms a consistent 16-bit value.
  - Hold ready=0 with cs & write to CTRL → no state change until ready=1.
